// File: rtl/ast_ldfifo_bank.sv
// Multi-channel lockstep FIFO bank with whole-array parallel load and an
// optional diagonal output skew (channel k emerges k cycles after channel 0).
module ast_ldfifo_bank #(
    parameter int DEPTH     = 8,
    parameter int DATAWIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int SKEW_EN   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rst_ptr,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     parallel_load,
    input  logic [DATAWIDTH-1:0]     array_in [NUM_CH][DEPTH],
    input  logic [DATAWIDTH-1:0]     data_in  [NUM_CH],
    output logic [DATAWIDTH-1:0]     data_out [NUM_CH],
    output logic [NUM_CH-1:0]        out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATAWIDTH-1:0] mem [NUM_CH][DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 pop_acc;
    logic                 push_acc;
    logic [NUM_CH-1:0]    pend;

    // Status flags come straight from count, so full/empty are never ambiguous.
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Pointer clear and parallel load both take precedence over push/pop;
    // a push may fill the slot freed by a same-cycle pop when full.
    assign pop_acc  = pop && !empty && !rst_ptr && !parallel_load;
    assign push_acc = push && (!full || pop_acc) && !rst_ptr && !parallel_load;

    // Anything still queued or still travelling through the skew chain.
    assign busy = (count != '0) || (|pend);

    // Shared pointers, occupancy count and the per-channel storage array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[k][i] <= '0;
                end
            end
        end else if (rst_ptr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (parallel_load) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= CW'(DEPTH);
            for (int k = 0; k < NUM_CH; k++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[k][i] <= array_in[k][i];
                end
            end
        end else begin
            if (push_acc) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    mem[k][wr_ptr] <= data_in[k];
                end
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_acc && !pop_acc) begin
                count <= count + CW'(1);
            end else if (pop_acc && !push_acc) begin
                count <= count - CW'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int LEN = (SKEW_EN != 0) ? k + 1 : 1;

        logic [DATAWIDTH-1:0] stg_data [LEN];
        logic [LEN-1:0]       stg_valid;

        // Output chain: stage 0 captures the popped word, later stages add the
        // per-channel delay; each stage only reloads data when valid arrives.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j < LEN; j++) begin
                    stg_data[j] <= '0;
                end
                stg_valid <= '0;
            end else if (rst_ptr) begin
                for (int j = 0; j < LEN; j++) begin
                    stg_data[j] <= '0;
                end
                stg_valid <= '0;
            end else begin
                stg_valid[0] <= pop_acc;
                if (pop_acc) begin
                    stg_data[0] <= mem[k][rd_ptr];
                end
                for (int j = 1; j < LEN; j++) begin
                    stg_valid[j] <= stg_valid[j-1];
                    if (stg_valid[j-1]) begin
                        stg_data[j] <= stg_data[j-1];
                    end
                end
            end
        end

        assign data_out[k]  = stg_data[LEN-1];
        assign out_valid[k] = stg_valid[LEN-1];

        if (LEN > 1) begin : g_pend
            assign pend[k] = |stg_valid[LEN-2:0];
        end else begin : g_nopend
            assign pend[k] = 1'b0;
        end
    end

endmodule
